// File: rtl/sprite_bounce_render.sv
// Bouncing square sprite renderer.
// The sprite position advances once per frame during vertical blanking,
// reflecting off the screen edges and counting bounce frames. Pixel
// colour and syncs pass through a two-stage pipeline.
`timescale 1ns/1ps
module sprite_bounce_render #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int Q_SIZE = 32,
  parameter int SPEED  = 2
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       enable,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [7:0] bounce_count
);

  localparam logic [9:0]  X_MAX  = 10'(H_RES - Q_SIZE);
  localparam logic [9:0]  X_TURN = 10'(H_RES - Q_SIZE - SPEED);
  localparam logic [9:0]  Y_MAX  = 10'(V_RES - Q_SIZE);
  localparam logic [9:0]  Y_TURN = 10'(V_RES - Q_SIZE - SPEED);
  localparam logic [9:0]  STEP   = 10'(SPEED);
  localparam logic [9:0]  TICK_Y = 10'(V_RES);
  localparam logic [10:0] QS     = 11'(Q_SIZE);

  // Motion state
  logic [9:0] qx_q, qx_d;
  logic [9:0] qy_q, qy_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic [7:0] bounce_q, bounce_d;

  // Pipeline stage 1
  logic s1_in_q, s1_de_q, s1_hs_q, s1_vs_q;
  // Pipeline stage 2 (output registers)
  logic [3:0] r_q, g_q, b_q;
  logic [3:0] r_d, g_d, b_d;
  logic       hs_q, vs_q;

  logic frame_tick;
  logic x_hit, y_hit;
  logic in_sprite;

  assign frame_tick = (sx == '0) && (sy == TICK_Y);

  // Next sprite position, direction and bounce count for this frame
  always_comb begin
    qx_d     = qx_q;
    qy_d     = qy_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = bounce_q;
    x_hit    = 1'b0;
    y_hit    = 1'b0;
    if (frame_tick && enable) begin
      if (!dir_x_q) begin
        if (qx_q >= X_TURN) begin
          qx_d    = X_MAX;
          dir_x_d = 1'b1;
          x_hit   = 1'b1;
        end else begin
          qx_d = qx_q + STEP;
        end
      end else begin
        if (qx_q <= STEP) begin
          qx_d    = '0;
          dir_x_d = 1'b0;
          x_hit   = 1'b1;
        end else begin
          qx_d = qx_q - STEP;
        end
      end
      if (!dir_y_q) begin
        if (qy_q >= Y_TURN) begin
          qy_d    = Y_MAX;
          dir_y_d = 1'b1;
          y_hit   = 1'b1;
        end else begin
          qy_d = qy_q + STEP;
        end
      end else begin
        if (qy_q <= STEP) begin
          qy_d    = '0;
          dir_y_d = 1'b0;
          y_hit   = 1'b1;
        end else begin
          qy_d = qy_q - STEP;
        end
      end
      // A corner hit touches both axes but still counts as one bounce frame
      if (x_hit || y_hit) begin
        bounce_d = bounce_q + 8'd1;
      end
    end
  end

  // Motion registers, updated only on the frame tick edge
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      qx_q     <= '0;
      qy_q     <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      bounce_q <= '0;
    end else begin
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      bounce_q <= bounce_d;
    end
  end

  // Sprite hit test, sums widened to 11 bits so qx+Q_SIZE cannot wrap
  assign in_sprite = ({1'b0, sx} >= {1'b0, qx_q}) &&
                     ({1'b0, sx} <  ({1'b0, qx_q} + QS)) &&
                     ({1'b0, sy} >= {1'b0, qy_q}) &&
                     ({1'b0, sy} <  ({1'b0, qy_q} + QS));

  // Stage 1: capture hit test and timing signals
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      s1_in_q <= 1'b0;
      s1_de_q <= 1'b0;
      s1_hs_q <= 1'b1;
      s1_vs_q <= 1'b1;
    end else begin
      s1_in_q <= in_sprite;
      s1_de_q <= de;
      s1_hs_q <= hsync;
      s1_vs_q <= vsync;
    end
  end

  // Pixel colour: blank, background, or sprite colour chosen by bounce count
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (s1_de_q) begin
      if (!s1_in_q) begin
        r_d = 4'h1;
        g_d = 4'h3;
        b_d = 4'h7;
      end else begin
        case (bounce_q[1:0])
          2'd0: begin r_d = 4'hF; g_d = 4'hF; b_d = 4'hF; end
          2'd1: begin r_d = 4'hF; g_d = 4'h0; b_d = 4'h0; end
          2'd2: begin r_d = 4'h0; g_d = 4'hF; b_d = 4'h0; end
          default: begin r_d = 4'h0; g_d = 4'h0; b_d = 4'hF; end
        endcase
      end
    end
  end

  // Stage 2: registered colour and delayed syncs
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= s1_hs_q;
      vs_q <= s1_vs_q;
    end
  end

  assign vga_r        = r_q;
  assign vga_g        = g_q;
  assign vga_b        = b_q;
  assign vga_hsync    = hs_q;
  assign vga_vsync    = vs_q;
  assign bounce_count = bounce_q;

endmodule

// File: tb/tb_sprite_bounce_render.sv
// Self-checking bench for sprite_bounce_render: directed table, frame-level
// milestones, enable hold, mid-frame reset and randomized pixel traffic.
`timescale 1ns/1ps
module tb_sprite_bounce_render;

  localparam int H = 640;
  localparam int V = 480;
  localparam int Q = 32;
  localparam int S = 2;

  typedef struct packed {
    logic [3:0] r, g, b;
    logic       hs, vs;
  } pix_t;

  typedef struct {
    pix_t  e;
    string nm;
  } exp_t;

  typedef struct {
    logic [9:0] sx, sy;
    logic       de, hs, vs;
    pix_t       exp;
  } vec_t;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic [9:0] sx = '0, sy = '0;
  logic       de = 1'b0, hsync = 1'b1, vsync = 1'b1, enable = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync;
  logic [7:0] bounce_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: sprite corner, directions, bounce frames
  int mqx, mqy, mcnt;
  bit mdx, mdy;
  exp_t expq[$];

  sprite_bounce_render #(.H_RES(H), .V_RES(V), .Q_SIZE(Q), .SPEED(S)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .enable(enable),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .bounce_count(bounce_count)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic pix_t mk(int r, int g, int b, bit h, bit v);
    pix_t p;
    p.r = 4'(r); p.g = 4'(g); p.b = 4'(b); p.hs = h; p.vs = v;
    return p;
  endfunction

  task automatic check_pix(input string nm, input pix_t got, input pix_t e);
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got rgb=%h%h%h hs=%b vs=%b, need rgb=%h%h%h hs=%b vs=%b",
               nm, got.r, got.g, got.b, got.hs, got.vs, e.r, e.g, e.b, e.hs, e.vs);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int e);
    n_cmp++;
    if (got != e) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", nm, got, e);
    end
  endtask

  // One axis of motion, stated directly from the bounce rules
  task automatic axis(inout int q, inout bit dir, input int res, output bit hit);
    int far_edge = res - Q;
    hit = 1'b0;
    if (!dir) begin
      if (q + S >= far_edge) begin q = far_edge; dir = 1'b1; hit = 1'b1; end
      else q = q + S;
    end else begin
      if (q - S <= 0) begin q = 0; dir = 1'b0; hit = 1'b1; end
      else q = q - S;
    end
  endtask

  // Expected pixel for an input vector; advances the model on a frame tick
  task automatic model(input int x, input int y, input bit d, input bit h, input bit v,
                       input bit en, output pix_t p);
    bit ins, hx, hy;
    ins = (x >= mqx) && (x < mqx + Q) && (y >= mqy) && (y < mqy + Q);
    if (x == 0 && y == V && en) begin
      axis(mqx, mdx, H, hx);
      axis(mqy, mdy, V, hy);
      if (hx || hy) mcnt = (mcnt + 1) % 256;
    end
    if (!d)        p = mk(0, 0, 0, h, v);
    else if (!ins) p = mk(1, 3, 7, h, v);
    else case (mcnt % 4)
      0:       p = mk(15, 15, 15, h, v);
      1:       p = mk(15, 0, 0, h, v);
      2:       p = mk(0, 15, 0, h, v);
      default: p = mk(0, 0, 15, h, v);
    endcase
  endtask

  // Called at a falling edge: check outputs due now, then drive the next vector
  task automatic step(input int x, input int y, input bit d, input bit h, input bit v,
                      input bit en, input bit use_k, input pix_t k, input string nm);
    exp_t old, nw;
    pix_t p;
    old = expq.pop_front();
    check_pix(old.nm, {vga_r, vga_g, vga_b, vga_hsync, vga_vsync}, old.e);
    check_int("bounce_count", int'(bounce_count), mcnt);
    model(x, y, d, h, v, en, p);
    nw.e  = use_k ? k : p;
    nw.nm = nm;
    expq.push_back(nw);
    sx = 10'(x); sy = 10'(y); de = d; hsync = h; vsync = v; enable = en;
    @(negedge clk_pix);
  endtask

  task automatic tick(input bit en);
    step(0, V, 0, 1, 1, en, 0, '0, "tick");
  endtask

  task automatic probe(input int x, input int y, input pix_t k, input string nm);
    step(x, y, 1, 1, 1, enable, 1, k, nm);
  endtask

  task automatic do_reset();
    exp_t r;
    #2 rst_pix = 1'b1;
    #1;
    check_pix("rst_async_out", {vga_r, vga_g, vga_b, vga_hsync, vga_vsync}, mk(0, 0, 0, 1, 1));
    check_int("rst_async_cnt", int'(bounce_count), 0);
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_pix = 1'b0;
    mqx = 0; mqy = 0; mdx = 0; mdy = 0; mcnt = 0;
    expq.delete();
    r.e = mk(0, 0, 0, 1, 1);
    r.nm = "post_rst";
    expq.push_back(r);
    expq.push_back(r);
  endtask

  vec_t tbl[8];

  initial begin
    int sqx, sqy, scnt, x;
    pix_t bg, wh;
    bg = mk(1, 3, 7, 1, 1);
    wh = mk(15, 15, 15, 1, 1);

    tbl[0] = '{sx: 10'd0,   sy: 10'd0,   de: 1, hs: 1, vs: 1, exp: mk(15, 15, 15, 1, 1)};
    tbl[1] = '{sx: 10'd40,  sy: 10'd5,   de: 1, hs: 1, vs: 1, exp: mk(1, 3, 7, 1, 1)};
    tbl[2] = '{sx: 10'd5,   sy: 10'd5,   de: 0, hs: 1, vs: 1, exp: mk(0, 0, 0, 1, 1)};
    tbl[3] = '{sx: 10'd31,  sy: 10'd31,  de: 1, hs: 1, vs: 1, exp: mk(15, 15, 15, 1, 1)};
    tbl[4] = '{sx: 10'd32,  sy: 10'd0,   de: 1, hs: 1, vs: 1, exp: mk(1, 3, 7, 1, 1)};
    tbl[5] = '{sx: 10'd0,   sy: 10'd32,  de: 1, hs: 1, vs: 1, exp: mk(1, 3, 7, 1, 1)};
    tbl[6] = '{sx: 10'd100, sy: 10'd100, de: 1, hs: 0, vs: 1, exp: mk(1, 3, 7, 0, 1)};
    tbl[7] = '{sx: 10'd1,   sy: 10'd1,   de: 1, hs: 1, vs: 0, exp: mk(15, 15, 15, 1, 0)};

    @(negedge clk_pix);
    do_reset();

    foreach (tbl[i])
      step(tbl[i].sx, tbl[i].sy, tbl[i].de, tbl[i].hs, tbl[i].vs, 0, 1, tbl[i].exp,
           $sformatf("table_%0d", i));

    // Frame milestones with motion enabled
    for (int f = 1; f <= 448; f++) begin
      tick(1);
      if (f == 1) begin
        probe(2, 2, wh, "f1_corner_in");
        probe(1, 2, bg, "f1_left_out");
        probe(33, 33, wh, "f1_far_in");
        probe(34, 2, bg, "f1_right_out");
      end
      if (f == 224) begin
        check_int("f224_cnt", int'(bounce_count), 1);
        probe(448, 448, mk(15, 0, 0, 1, 1), "f224_in");
        probe(479, 479, mk(15, 0, 0, 1, 1), "f224_far_in");
        probe(448, 447, bg, "f224_above");
        probe(480, 448, bg, "f224_right");
      end
      if (f == 304) begin
        check_int("f304_cnt", int'(bounce_count), 2);
        probe(608, 288, mk(0, 15, 0, 1, 1), "f304_in");
        probe(607, 288, bg, "f304_left");
      end
      if (f == 448) begin
        check_int("f448_cnt", int'(bounce_count), 3);
        probe(320, 0, mk(0, 0, 15, 1, 1), "f448_in");
        probe(351, 31, mk(0, 0, 15, 1, 1), "f448_far_in");
        probe(352, 0, bg, "f448_right");
        probe(320, 32, bg, "f448_below");
      end
    end

    // Motion frozen while enable is low
    sqx = mqx; sqy = mqy; scnt = mcnt;
    for (int i = 0; i < 10; i++) tick(0);
    check_int("hold_cnt", int'(bounce_count), scnt);
    probe(sqx, sqy, mk(0, 0, 15, 1, 1), "hold_in");
    probe(sqx + Q, sqy, bg, "hold_out");
    tick(1);
    probe(sqx, sqy, bg, "resume_old_corner");
    probe(sqx - S, sqy + S, mk(0, 0, 15, 1, 1), "resume_new_corner");

    // Reset in the middle of an active frame after 50 frames of motion
    do_reset();
    for (int f = 0; f < 50; f++) tick(1);
    step(300, 200, 1, 1, 1, 1, 0, '0, "pre_rst");
    do_reset();
    tick(1);
    probe(2, 2, wh, "rst_restart_in");
    probe(1, 2, bg, "rst_restart_out");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r, y;
      bit en;
      r  = int'($urandom % 8);
      en = ($urandom % 10) != 0;
      if (r == 0) begin
        step(0, V, $urandom % 2, $urandom % 2, $urandom % 2, en, 0, '0, "rand_tick");
      end else begin
        if (r < 5) begin
          x = mqx + int'($urandom_range(0, 40)) - 4;
          y = mqy + int'($urandom_range(0, 40)) - 4;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end else begin
          x = int'($urandom % 1024);
          y = int'($urandom % 1024);
        end
        step(x, y, ($urandom % 4) != 0, $urandom % 2, $urandom % 2, en, 0, '0, "rand_pix");
      end
    end

    // Flush the pipeline
    step(0, 0, 0, 1, 1, 0, 0, '0, "flush");
    step(0, 0, 0, 1, 1, 0, 0, '0, "flush");
    step(0, 0, 0, 1, 1, 0, 0, '0, "flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_bounce_render.md
SPRITE_BOUNCE_RENDER -- requirements
Module: sprite_bounce_render

Interface
REQ-001 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-003 SHALL have parameter Q_SIZE, default 32, sprite edge length in pixels.
REQ-004 SHALL have parameter SPEED, default 2, pixels moved per axis per frame.
REQ-005 SHALL have clk_pix  input  1  pixel clock, the only clock.
REQ-006 SHALL have rst_pix  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have sx  input  10  horizontal position from the timing generator.
REQ-008 SHALL have sy  input  10  vertical position from the timing generator.
REQ-009 SHALL have de  input  1  data enable, high in active area.
REQ-010 SHALL have hsync, vsync  input  1 each  negative-polarity syncs from the timing generator.
REQ-011 SHALL have enable  input  1  high allows sprite motion.
REQ-012 SHALL have vga_r, vga_g, vga_b  output  4 each  registered colour.
REQ-013 SHALL have vga_hsync, vga_vsync  output  1 each  syncs delayed to match colour.
REQ-014 SHALL have bounce_count  output  8  number of frames containing a bounce, wraps 255->0.

Function
REQ-015 SHALL generate internal frame_tick for one cycle when sx==0 and sy==V_RES.
REQ-016 SHALL hold registers qx, qy (10 bit, sprite top-left) and dir_x, dir_y (0=right/down, 1=left/up).
REQ-017 SHALL update motion on the edge after frame_tick only if enable==1; else qx, qy, dir_*, bounce_count hold.
REQ-018 X moving right: if qx >= H_RES-Q_SIZE-SPEED then qx<=H_RES-Q_SIZE, dir_x<=1, x_hit; else qx<=qx+SPEED.
REQ-019 X moving left: if qx <= SPEED then qx<=0, dir_x<=0, x_hit; else qx<=qx-SPEED.
REQ-020 Y axis SHALL follow REQ-018/019 with V_RES, qy, dir_y, y_hit.
REQ-021 bounce_count SHALL increment by exactly 1 when x_hit or y_hit (corner hit = one increment).
REQ-022 in_sprite SHALL be sx>=qx and sx<qx+Q_SIZE and sy>=qy and sy<qy+Q_SIZE, sums computed 11 bit (no wrap).
REQ-023 Pipeline stage 1 SHALL register in_sprite, de, hsync, vsync; stage 2 SHALL register colour and syncs; latency exactly 2 cycles from inputs to outputs.
REQ-024 Stage 2 with de==0: RGB 0/0/0.
REQ-025 Stage 2 with de==1, in_sprite==0: background RGB 1/3/7.
REQ-026 Stage 2 with de==1, in_sprite==1: colour by bounce_count[1:0]: 0=F/F/F, 1=F/0/0, 2=0/F/0, 3=0/0/F.
REQ-027 Colour and sync outputs SHALL update every cycle regardless of enable.
REQ-028 Motion registers SHALL change only in vertical blanking (edge after frame_tick), never mid-active-frame.

Reset
REQ-029 rst_pix high SHALL immediately clear qx=0, qy=0, dir_x=0, dir_y=0, bounce_count=0.
REQ-030 rst_pix high SHALL immediately force vga_r/g/b=0, vga_hsync=1, vga_vsync=1, all pipeline stage regs to de=0, syncs=1.
REQ-031 Reset asserted mid-frame SHALL abort any pending update; first frame_tick after release moves sprite from (0,0).
REQ-032 Outputs SHALL track inputs normally starting 2 cycles after reset release.

Verification
REQ-033 After reset, present sx=0,sy=0,de=1 -> two cycles later RGB=F/F/F; sx=40,sy=5,de=1 -> 1/3/7; de=0 -> 0/0/0.
REQ-034 Drive hsync=0 on cycle N with vsync=1 -> vga_hsync=0 on cycle N+2, vga_vsync stays 1.
REQ-035 enable=1, run full 800x525 frames -> after 1 frame qx=2,qy=2; after frame 224 qy=448, dir_y=1, bounce_count=1, sprite colour F/0/0.
REQ-036 Continue -> frame 304 qx=608, dir_x=1, bounce_count=2; frame 448 qy=0, dir_y=0, bounce_count=3.
REQ-037 enable=0 across 10 frame_ticks -> qx, qy, bounce_count unchanged; enable=1 resumes from same values.
REQ-038 Assert rst_pix at sx=300,sy=200 after 50 frames -> outputs 0/0/0, syncs 1 same cycle; after release next frame_tick gives qx=2,qy=2.
